if_fetch_unit: RTL

Instruction-fetch front end of the RV32I pipeline: owns the fetch PC, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small queue. It drives the decode stage's instruction input (`instruction_i`) together with the matching PC. It also honours decode-side stalls and EX-stage redirects (taken branch/jump), discarding any stale in-flight fetch.

---
 rtl/if_fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one in-flight word
// request at a time and buffers returned instructions with their PCs for decode.
module if_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  stall_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);

  localparam int                    PW  = $clog2(FIFO_DEPTH);
  localparam int                    CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  out_q, out_d;
  logic                  drop_q, drop_d;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] tag_q;
  logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];

  logic                  valid, pop, resp, push, grant, space;
  logic [CW:0]           occupancy;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign valid = !rst && (count_q != '0);
  assign pop   = valid && !stall_i && !redirect_i;
  assign resp  = imem_rvalid_i && out_q;
  assign push  = resp && !drop_q && !redirect_i;

  // A response arriving this cycle still needs its slot, so every live
  // (non-dropped) request counts against the queue until it is stored.
  assign occupancy = {1'b0, count_q} + (CW+1)'(out_q && !drop_q) - (CW+1)'(pop);
  assign space     = occupancy < (CW+1)'(FIFO_DEPTH);

  assign imem_req_o  = !rst && !redirect_i && space && (!out_q || imem_rvalid_i);
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  assign valid_o       = valid;
  assign instruction_o = valid ? instr_mem_q[rd_q] : NOP;
  assign pc_o          = valid ? pc_mem_q[rd_q] : '0;
  assign pc_plus4_o    = valid ? pc_mem_q[rd_q] + DATA_WIDTH'(4) : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    if (redirect_i) begin
      // A response landing in the redirect cycle is simply discarded; one
      // still in flight must be dropped when it eventually returns.
      fetch_pc_d = redirect_target;
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      out_d      = out_q && !imem_rvalid_i;
      drop_d     = out_q && !imem_rvalid_i;
    end else begin
      if (resp) begin
        out_d  = 1'b0;
        drop_d = 1'b0;
      end
      if (grant) begin
        out_d      = 1'b1;
        fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      end
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= 1'b0;
      drop_q     <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_q <= fetch_pc_q;
    if (push) begin
      instr_mem_q[wr_q] <= imem_rdata_i;
      pc_mem_q[wr_q]    <= tag_q;
    end
  end

endmodule
